ref_pix_axi_rd_slave_model: RTL



---
 rtl/ref_pix_axi_rd_slave_model_if.sv | 33 +++
 rtl/ref_pix_axi_rd_slave_model.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/ref_pix_axi_rd_slave_model_if.sv
// AXI4 read-channel bundle (AR + R) between the reference-pixel cache master
// and the read-slave memory model.
interface ref_pix_axi_rd_slave_model_if #(
    parameter int AXI_ADDR_WDTH = 32,
    parameter int AXI_DATA_WDTH = 512
);
    logic [AXI_ADDR_WDTH-1:0] ar_addr;
    logic [7:0]               ar_len;
    logic [2:0]               ar_size;
    logic [1:0]               ar_burst;
    logic [2:0]               ar_prot;
    logic                     ar_valid;
    logic                     ar_ready;
    logic [AXI_DATA_WDTH-1:0] r_data;
    logic [1:0]               r_resp;
    logic                     r_last;
    logic                     r_valid;
    logic                     r_ready;

    modport master (
        output ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_valid,
        input  ar_ready,
        input  r_data, r_resp, r_last, r_valid,
        output r_ready
    );

    modport slave (
        input  ar_addr, ar_len, ar_size, ar_burst, ar_prot, ar_valid,
        output ar_ready,
        output r_data, r_resp, r_last, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/ref_pix_axi_rd_slave_model.sv
// AXI4 read-slave memory model: queues AR requests, waits a minimum latency and
// returns INCR bursts whose byte i is (beat address + i) mod 256. Optional R-beat
// bubbles are enabled with `define RD_SLAVE_GAP_EN.
module ref_pix_axi_rd_slave_model #(
    parameter int AXI_ADDR_WDTH   = 32,
    parameter int AXI_DATA_WDTH   = 512,
    parameter int MAX_OUTSTANDING = 4,
    parameter int READ_LATENCY    = 8,
    parameter int TS_WDTH         = 16,
    parameter int GAP_PERIOD      = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    ref_pix_axi_rd_slave_model_if.slave  axi,
    output logic                         proto_err,
    output logic                         idle,
    output logic [31:0]                  beat_cnt
);
    localparam int BYTES     = AXI_DATA_WDTH / 8;
    localparam int SIZE_LOG2 = $clog2(BYTES);
    localparam int PTR_W     = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W     = PTR_W + 1;

    typedef enum logic {ST_IDLE, ST_BURST} state_t;

    state_t                   state, next_state;
    logic [AXI_ADDR_WDTH-1:0] fifo_addr [MAX_OUTSTANDING];
    logic [7:0]               fifo_len  [MAX_OUTSTANDING];
    logic [TS_WDTH-1:0]       fifo_ts   [MAX_OUTSTANDING];
    logic [PTR_W-1:0]         wr_ptr, rd_ptr;
    logic [CNT_W-1:0]         fifo_cnt, fifo_cnt_next;
    logic [TS_WDTH-1:0]       ts, head_age;
    logic [AXI_ADDR_WDTH-1:0] cur_addr;
    logic [8:0]               beats_left;
    logic [31:0]              span_end;
    logic                     push, pop, head_eligible, r_hs, last_hs;
    logic                     burst_err, gap_active;
    logic                     unused_prot;

    assign unused_prot   = ^axi.ar_prot;
    assign push          = axi.ar_valid & axi.ar_ready;
    assign r_hs          = axi.r_valid & axi.r_ready;
    assign last_hs       = r_hs && (beats_left == 9'd1);
    assign fifo_cnt_next = fifo_cnt + CNT_W'(push) - CNT_W'(pop);

    // Modular age keeps eligibility correct across timestamp wrap.
    assign head_age      = ts - fifo_ts[rd_ptr];
    assign head_eligible = (fifo_cnt != '0) && (head_age >= TS_WDTH'(READ_LATENCY));

    assign span_end  = 32'(axi.ar_addr[11:0]) + (32'(axi.ar_len) + 32'd1) * 32'(BYTES);
    assign burst_err = (axi.ar_burst != 2'b01) || (axi.ar_size != 3'(SIZE_LOG2)) ||
                       (span_end > 32'd4096);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ts           <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            fifo_cnt     <= '0;
            axi.ar_ready <= 1'b0;
            proto_err    <= 1'b0;
        end else begin
            ts           <= ts + 1'b1;
            fifo_cnt     <= fifo_cnt_next;
            axi.ar_ready <= (fifo_cnt_next < CNT_W'(MAX_OUTSTANDING));
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && burst_err) proto_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr[wr_ptr] <= axi.ar_addr;
            fifo_len[wr_ptr]  <= axi.ar_len;
            fifo_ts[wr_ptr]   <= ts;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        pop        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (head_eligible) begin
                    pop        = 1'b1;
                    next_state = ST_BURST;
                end
            end
            ST_BURST: begin
                // Chain straight into the next burst when its latency has already elapsed.
                if (last_hs) begin
                    if (head_eligible) pop = 1'b1;
                    else               next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cur_addr   <= '0;
            beats_left <= '0;
            beat_cnt   <= '0;
        end else begin
            if (pop) begin
                cur_addr   <= fifo_addr[rd_ptr];
                beats_left <= {1'b0, fifo_len[rd_ptr]} + 9'd1;
            end else if (r_hs) begin
                cur_addr   <= cur_addr + AXI_ADDR_WDTH'(BYTES);
                beats_left <= beats_left - 9'd1;
            end
            if (r_hs) beat_cnt <= beat_cnt + 32'd1;
        end
    end

`ifdef RD_SLAVE_GAP_EN
    localparam int GAP_W = $clog2(GAP_PERIOD) + 1;
    logic [GAP_W-1:0] gap_cnt;
    logic             gap_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gap_cnt <= '0;
            gap_q   <= 1'b0;
        end else if (pop) begin
            gap_cnt <= '0;
            gap_q   <= 1'b0;
        end else if (gap_q) begin
            gap_q   <= 1'b0;
        end else if (r_hs && !last_hs) begin
            if (gap_cnt == GAP_W'(GAP_PERIOD - 1)) begin
                gap_cnt <= '0;
                gap_q   <= 1'b1;
            end else begin
                gap_cnt <= gap_cnt + 1'b1;
            end
        end
    end

    assign gap_active = gap_q;
`else
    localparam int unused_gap_period = GAP_PERIOD;
    assign gap_active = 1'b0;
`endif

    assign axi.r_valid = (state == ST_BURST) && !gap_active;
    assign axi.r_last  = axi.r_valid && (beats_left == 9'd1);
    assign axi.r_resp  = 2'b00;
    assign idle        = (fifo_cnt == '0) && (state == ST_IDLE);

    always_comb begin
        axi.r_data = '0;
        if (axi.r_valid) begin
            for (int i = 0; i < BYTES; i++) begin
                axi.r_data[i*8 +: 8] = cur_addr[7:0] + 8'(i);
            end
        end
    end
endmodule
